// File: rtl/contador_rolhas_param.sv
// -----------------------------------------------------------------------------
// contador_rolhas_param
//
// Cork-stock counter for the bottling line feeder. COUNT holds the corks left
// in the feeder. It drops by one for each CONSUME cycle. Each acknowledged
// refill adds REFILL_AMOUNT corks, and the result saturates at MAX. A two-state
// FSM raises REFILL_REQ towards the supply station when stock is low. It drops
// REFILL_REQ again when the station acknowledges (REFILL_ACK) or when a LOAD
// occurs.
//
// Parameters
//   WIDTH          counter width in bits
//   INIT           COUNT value after reset
//   MAX            saturation ceiling (INIT <= MAX <= 2^WIDTH-1)
//   LOW_LEVEL      LOW threshold (LOW_LEVEL < MAX)
//   REFILL_AMOUNT  corks added per acknowledged refill (>= 1)
//
// Ports
//   clock_i        sole clock, rising edge
//   reset_ni       synchronous active-low reset
//   load_i         load dados_i (clamped to MAX); beats consume/refill
//   dados_i        load value
//   consume_i      one cork consumed this cycle
//   refill_ack_i   supply delivered a batch; honoured only while requesting
//   count_o        corks remaining (registered)
//   zero_o         count_o == 0
//   low_o          count_o <= LOW_LEVEL
//   refill_req_o   refill request (FSM in REQ)
//   error_o        sticky underflow flag, cleared by load or reset
// -----------------------------------------------------------------------------
module contador_rolhas_param #(
    parameter int WIDTH         = 7,
    parameter int INIT          = 99,
    parameter int MAX           = 99,
    parameter int LOW_LEVEL     = 5,
    parameter int REFILL_AMOUNT = 20
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] dados_i,
    input  logic             consume_i,
    input  logic             refill_ack_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o,
    output logic             low_o,
    output logic             refill_req_o,
    output logic             error_o
);

    localparam logic [WIDTH-1:0] INIT_N = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] LOW_N  = WIDTH'(LOW_LEVEL);
    // Two guard bits let count + batch be computed without wrapping
    // before the saturation check.
    localparam logic [WIDTH+1:0] MAX_W  = (WIDTH+2)'(MAX);
    localparam logic [WIDTH+1:0] ADD_W  = (WIDTH+2)'(REFILL_AMOUNT);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             error_q, error_d;

    logic             ack_valid;
    logic [WIDTH+1:0] add_w;
    logic [WIDTH+1:0] sub_w;
    logic [WIDTH+1:0] sum_w;
    logic             underflow;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // The request is based on the count before this edge. A
                // refill that leaves the stock still low therefore
                // re-requests one edge later.
                if (!load_i && (count_q <= LOW_N)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (refill_ack_i || load_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        refill_req_o = (state_q == REQ);
    end

    // ------------------------------------------------------------------
    // Counter / error datapath
    // ------------------------------------------------------------------
    always_comb begin
        ack_valid = refill_ack_i && (state_q == REQ);
        add_w     = ack_valid ? ADD_W : '0;
        sub_w     = {{(WIDTH+1){1'b0}}, consume_i};
        sum_w     = {2'b00, count_q} + add_w - sub_w;
        // A batch arriving on the same edge covers the cork, so only an
        // unfunded consume at zero counts as an underflow. Outside that
        // case sum_w is never negative, so an unsigned compare against
        // MAX is enough.
        underflow = (count_q == '0) && consume_i && !ack_valid;

        count_d = count_q;
        error_d = error_q;
        if (load_i) begin
            count_d = (dados_i > MAX_N) ? MAX_N : dados_i;
            error_d = 1'b0;
        end else if (underflow) begin
            count_d = '0;
            error_d = 1'b1;
        end else if (sum_w > MAX_W) begin
            count_d = MAX_N;
        end else begin
            count_d = sum_w[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            count_q <= INIT_N;
            error_q <= 1'b0;
        end else begin
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign count_o = count_q;
    assign error_o = error_q;
    assign zero_o  = (count_q == '0);
    assign low_o   = (count_q <= LOW_N);

endmodule

// File: tb/tb_contador_rolhas_param.sv
// -----------------------------------------------------------------------------
// tb_contador_rolhas_param
//
// Directed testbench for contador_rolhas_param. Two instances share the same
// stimulus:
//   dut_a  default parameters (batch of 20)
//   dut_b  REFILL_AMOUNT = 120, used for the saturation checks
// The bench drives inputs 1 time unit after a rising edge and samples outputs
// 1 time unit after the following edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_contador_rolhas_param;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load = 1'b0;
    logic [6:0] dados = '0;
    logic       consume = 1'b0;
    logic       ack = 1'b0;

    logic [6:0] count_a, count_b;
    logic       zero_a, low_a, req_a, err_a;
    logic       zero_b, low_b, req_b, err_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    contador_rolhas_param dut_a (
        .clock_i      (clk),
        .reset_ni     (reset_n),
        .load_i       (load),
        .dados_i      (dados),
        .consume_i    (consume),
        .refill_ack_i (ack),
        .count_o      (count_a),
        .zero_o       (zero_a),
        .low_o        (low_a),
        .refill_req_o (req_a),
        .error_o      (err_a)
    );

    contador_rolhas_param #(.REFILL_AMOUNT(120)) dut_b (
        .clock_i      (clk),
        .reset_ni     (reset_n),
        .load_i       (load),
        .dados_i      (dados),
        .consume_i    (consume),
        .refill_ack_i (ack),
        .count_o      (count_b),
        .zero_o       (zero_b),
        .low_o        (low_b),
        .refill_req_o (req_b),
        .error_o      (err_b)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply a LOAD, then leave the FSM one further edge to raise its request.
    task automatic load_and_request(input logic [6:0] v);
        load = 1'b1; dados = v; step();
        load = 1'b0; step();
    endtask

    initial begin
        // ---------------- Reset ----------------
        reset_n = 1'b0;
        step(); step();
        check_val("rst_count", count_a, 99);
        check_val("rst_zero",  zero_a,  0);
        check_val("rst_low",   low_a,   0);
        check_val("rst_req",   req_a,   0);
        check_val("rst_err",   err_a,   0);
        reset_n = 1'b1;

        // ---------------- Drain to threshold ----------------
        consume = 1'b1;
        for (int i = 1; i <= 94; i++) begin
            step();
            if (i == 93) begin
                check_val("drain93_count", count_a, 6);
                check_val("drain93_low",   low_a,   0);
            end
        end
        check_val("drain94_count", count_a, 5);
        check_val("drain94_low",   low_a,   1);
        check_val("drain94_req",   req_a,   0);
        consume = 1'b0;
        step();
        check_val("drain_req_rise", req_a, 1);
        check_val("drain_hold_cnt", count_a, 5);

        // ---------------- Refill with simultaneous consume ----------------
        ack = 1'b1; consume = 1'b1;
        step();
        check_val("refill_count", count_a, 24);
        check_val("refill_req",   req_a,   0);
        ack = 1'b0; consume = 1'b0;
        step();
        check_val("refill_idle_req", req_a, 0);
        ack = 1'b1;
        step();
        check_val("ack_idle_count", count_a, 24);
        check_val("ack_idle_err",   err_a,   0);
        ack = 1'b0;

        // ---------------- Underflow ----------------
        load = 1'b1; dados = 7'd0;
        step();
        check_val("ld0_count", count_a, 0);
        check_val("ld0_zero",  zero_a,  1);
        check_val("ld0_req",   req_a,   0);
        load = 1'b0; consume = 1'b1;
        step();
        check_val("uf1_count", count_a, 0);
        check_val("uf1_err",   err_a,   1);
        check_val("uf1_req",   req_a,   1);
        step(); step();
        check_val("uf3_count", count_a, 0);
        check_val("uf3_zero",  zero_a,  1);
        check_val("uf3_err",   err_a,   1);
        check_val("uf3_req",   req_a,   1);
        consume = 1'b0;
        load = 1'b1; dados = 7'd10;
        step();
        check_val("ld10_count", count_a, 10);
        check_val("ld10_err",   err_a,   0);
        check_val("ld10_req",   req_a,   0);
        load = 1'b0;
        step();
        check_val("ld10_noreq", req_a, 0);

        // ---------------- Consume at zero with valid ACK ----------------
        load_and_request(7'd0);
        check_val("z_ack_req", req_a, 1);
        ack = 1'b1; consume = 1'b1;
        step();
        check_val("z_ack_count", count_a, 19);
        check_val("z_ack_err",   err_a,   0);
        ack = 1'b0; consume = 1'b0;

        // ---------------- Saturation and clamp ----------------
        load_and_request(7'd3);
        check_val("sat_req_b", req_b, 1);
        ack = 1'b1;
        step();
        check_val("sat_count_b", count_b, 99);
        check_val("sat_req_b0",  req_b,   0);
        check_val("sat_count_a", count_a, 23);
        ack = 1'b0;
        load = 1'b1; dados = 7'd127;
        step();
        check_val("clamp_count_a", count_a, 99);
        check_val("clamp_count_b", count_b, 99);
        load = 1'b0;

        // ---------------- Reset mid-request ----------------
        load_and_request(7'd2);
        check_val("mid_req", req_a, 1);
        reset_n = 1'b0; ack = 1'b1;
        step();
        check_val("rstmid_count", count_a, 99);
        check_val("rstmid_req",   req_a,   0);
        reset_n = 1'b1; ack = 1'b0;
        step();
        check_val("rstmid_req2",  req_a,   0);

        // ---------------- LOAD mid-request ----------------
        load_and_request(7'd2);
        check_val("mid2_req", req_a, 1);
        load = 1'b1; dados = 7'd50; ack = 1'b1;
        step();
        check_val("ldmid_count", count_a, 50);
        check_val("ldmid_req",   req_a,   0);
        load = 1'b0; ack = 1'b0;
        step();
        check_val("ldmid_noreq", req_a,   0);
        check_val("ldmid_cnt2",  count_a, 50);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
